rom_arbiter: RTL and testbench

- Shares the single-read-port instruction ROM (4 KB, 1024 x 32-bit) between three requesters:
  - core instruction fetch (IF)
  - core data load (LD)
  - host-bridge program loader (WR)
- Sequences a BOOT phase, during which only the loader may write the image, and a RUN phase, during which IF and LD arbitrate for reads.
- Tracks the ROM's one-cycle registered-address read latency and routes each returned word to the requester that issued it.
- Sits between the rv32i core front/back ends and the ROM macro.

---
 rtl/rom_arbiter_pkg.sv | 27 ++
 rtl/rom_arbiter.sv | 125 ++++++++++++
 tb/tb_rom_arbiter.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_arbiter_pkg.sv
// Shared types and constants for the instruction-ROM arbiter.
//   owner_e      : which requester a pending read response belongs to
//   arb_state_e  : BOOT (loader writes the image) / RUN (IF and LD read)
//   addr_bad     : flags a misaligned or out-of-range byte address
package rom_arbiter_pkg;

    localparam int ROM_DEPTH_LOG2 = 10;

    typedef enum logic [1:0] {
        OWNER_NONE = 2'd0,
        OWNER_IF   = 2'd1,
        OWNER_LD   = 2'd2
    } owner_e;

    typedef enum logic [0:0] {
        ARB_BOOT = 1'b0,
        ARB_RUN  = 1'b1
    } arb_state_e;

    // A word access must be aligned and every bit above the word index must be zero.
    function automatic logic addr_bad(input logic [31:0] addr, input int depth_log2);
        logic [31:0] upper;
        upper = addr >> (depth_log2 + 2);
        return (addr[1:0] != 2'b00) || (upper != 32'd0);
    endfunction

endpackage

// File: rtl/rom_arbiter.sv
// Arbiter in front of the single-port instruction ROM.
// state    | meaning
// ARB_BOOT | only the host loader may write; core held in reset (running = 0)
// ARB_RUN  | IF and LD compete for one read per cycle; left only by reset
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   if_req/if_addr/if_gnt      fetch request channel; if_rvalid/if_rdata/if_err response
//   ld_req/ld_addr/ld_gnt      load request channel;  ld_rvalid/ld_rdata/ld_err response
//   wr_req/wr_addr/wr_data     loader write channel; wr_gnt acceptance
//   boot_done                  loader pulse ending BOOT
//   running                    high in RUN
//   rom_addr/rom_we/rom_wdata  ROM macro inputs; rom_data returns one cycle later
module rom_arbiter
    import rom_arbiter_pkg::*;
#(
    parameter int DEPTH_LOG2    = ROM_DEPTH_LOG2,
    parameter int STARVE_LIMIT  = 4,
    parameter int BOOT_ON_RESET = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    output logic        if_err,
    input  logic        ld_req,
    input  logic [31:0] ld_addr,
    output logic        ld_gnt,
    output logic        ld_rvalid,
    output logic [31:0] ld_rdata,
    output logic        ld_err,
    input  logic        wr_req,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_gnt,
    input  logic        boot_done,
    output logic        running,
    output logic [31:0] rom_addr,
    output logic        rom_we,
    output logic [31:0] rom_wdata,
    input  logic [31:0] rom_data
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] STARVE_MAX = CW'(STARVE_LIMIT);

    arb_state_e    state;
    logic [CW-1:0] starve_cnt;
    owner_e        resp_owner;
    logic          resp_err;
    logic [31:0]   if_rdata_q;
    logic [31:0]   ld_rdata_q;
    logic          if_win;
    logic          ld_win;

    // LD has priority on contention until IF has waited STARVE_LIMIT cycles.
    always_comb begin
        if_win = 1'b0;
        ld_win = 1'b0;
        if (state == ARB_RUN) begin
            if (if_req && ld_req) begin
                if (starve_cnt >= STARVE_MAX) if_win = 1'b1;
                else                          ld_win = 1'b1;
            end else begin
                if_win = if_req;
                ld_win = ld_req;
            end
        end
    end

    assign if_gnt    = if_win;
    assign ld_gnt    = ld_win;
    assign wr_gnt    = (state == ARB_BOOT) && wr_req;
    // A bad loader address is acknowledged so the loader moves on, but never written.
    assign rom_we    = wr_gnt && !addr_bad(wr_addr, DEPTH_LOG2);
    assign rom_wdata = wr_data;
    assign rom_addr  = (state == ARB_BOOT) ? wr_addr : (ld_win ? ld_addr : if_addr);
    assign running   = (state == ARB_RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= (BOOT_ON_RESET != 0) ? ARB_BOOT : ARB_RUN;
            starve_cnt <= '0;
            resp_owner <= OWNER_NONE;
            resp_err   <= 1'b0;
        end else begin
            if (state == ARB_BOOT && boot_done) state <= ARB_RUN;

            if (state == ARB_RUN && if_req && !if_win) begin
                if (starve_cnt < STARVE_MAX) starve_cnt <= starve_cnt + 1'b1;
            end else begin
                starve_cnt <= '0;
            end

            if (if_win)      resp_owner <= OWNER_IF;
            else if (ld_win) resp_owner <= OWNER_LD;
            else             resp_owner <= OWNER_NONE;

            resp_err <= (if_win && addr_bad(if_addr, DEPTH_LOG2)) ||
                        (ld_win && addr_bad(ld_addr, DEPTH_LOG2));
        end
    end

    // Non-owner rdata holds the last word delivered to it.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            if_rdata_q <= '0;
            ld_rdata_q <= '0;
        end else begin
            if (resp_owner == OWNER_IF) if_rdata_q <= if_rdata;
            if (resp_owner == OWNER_LD) ld_rdata_q <= ld_rdata;
        end
    end

    assign if_rvalid = (resp_owner == OWNER_IF);
    assign ld_rvalid = (resp_owner == OWNER_LD);
    assign if_err    = if_rvalid && resp_err;
    assign ld_err    = ld_rvalid && resp_err;
    assign if_rdata  = if_rvalid ? (resp_err ? 32'd0 : rom_data) : if_rdata_q;
    assign ld_rdata  = ld_rvalid ? (resp_err ? 32'd0 : rom_data) : ld_rdata_q;

endmodule

// File: tb/tb_rom_arbiter.sv
module tb_rom_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ld_req, wr_req, boot_done;
    logic [31:0] if_addr, ld_addr, wr_addr, wr_data;
    logic        if_gnt, if_rvalid, if_err, ld_gnt, ld_rvalid, ld_err, wr_gnt;
    logic [31:0] if_rdata, ld_rdata, rom_addr, rom_wdata;
    logic        running, rom_we;
    logic [31:0] rom_data;

    // second instance: BOOT_ON_RESET = 0
    logic        z_req = 1'b0;
    logic [31:0] z_word = 32'd0;
    logic        d2_if_gnt, d2_if_rvalid, d2_if_err, d2_ld_gnt, d2_ld_rvalid, d2_ld_err;
    logic        d2_wr_gnt, d2_running, d2_rom_we;
    logic [31:0] d2_if_rdata, d2_ld_rdata, d2_rom_addr, d2_rom_wdata;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rom_arbiter #(.DEPTH_LOG2(10), .STARVE_LIMIT(4), .BOOT_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
        .if_rdata(if_rdata), .if_err(if_err),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
        .ld_rdata(ld_rdata), .ld_err(ld_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .boot_done(boot_done), .running(running),
        .rom_addr(rom_addr), .rom_we(rom_we), .rom_wdata(rom_wdata), .rom_data(rom_data)
    );

    rom_arbiter #(.DEPTH_LOG2(10), .STARVE_LIMIT(4), .BOOT_ON_RESET(0)) dut2 (
        .clk(clk), .rst_n(rst_n),
        .if_req(z_req), .if_addr(z_word), .if_gnt(d2_if_gnt), .if_rvalid(d2_if_rvalid),
        .if_rdata(d2_if_rdata), .if_err(d2_if_err),
        .ld_req(z_req), .ld_addr(z_word), .ld_gnt(d2_ld_gnt), .ld_rvalid(d2_ld_rvalid),
        .ld_rdata(d2_ld_rdata), .ld_err(d2_ld_err),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(d2_wr_gnt),
        .boot_done(boot_done), .running(d2_running),
        .rom_addr(d2_rom_addr), .rom_we(d2_rom_we), .rom_wdata(d2_rom_wdata), .rom_data(z_word)
    );

    // ROM macro model: registered address, one-cycle read latency.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (rom_we) mem[rom_addr[11:2]] <= rom_wdata;
        rom_data <= mem[rom_addr[11:2]];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Image contents written by the loader.
    function automatic logic [31:0] exp_word(input int idx);
        return (idx < 4) ? 32'h0000_0013 : 32'hA000_0000 + 32'(idx);
    endfunction

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 32'h1000);
    endfunction

    function automatic logic [31:0] rnd_addr();
        int r;
        r = int'($urandom_range(0, 7));
        if (r == 0) return 32'h1000 + 32'($urandom_range(0, 255)) * 4;
        if (r == 1) return 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        return 32'($urandom_range(0, 15)) * 4;
    endfunction

    typedef struct {
        logic        if_req;
        logic [31:0] if_addr;
        logic        ld_req;
        logic [31:0] ld_addr;
        logic        e_if;
        logic        e_ld;
        logic        e_err;
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs [9];

    initial begin
        logic [31:0] a;
        bit bad, exp_if, exp_ld, pv_if, pv_ld, p_err, ir, lr;
        logic [31:0] p_data;
        int starve;

        for (int i = 0; i < 1024; i++) mem[i] = 32'd0;

        vecs[0] = '{1'b1, 32'h8,        1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'h0000_0013};
        vecs[1] = '{1'b0, 32'h0,        1'b1, 32'h14,   1'b0, 1'b1, 1'b0, 32'hA000_0005};
        vecs[2] = '{1'b1, 32'h4,        1'b1, 32'h18,   1'b0, 1'b1, 1'b0, 32'hA000_0006};
        vecs[3] = '{1'b0, 32'h0,        1'b1, 32'h1002, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[4] = '{1'b1, 32'h6,        1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h0};
        vecs[5] = '{1'b0, 32'h0,        1'b1, 32'h1000, 1'b0, 1'b1, 1'b1, 32'h0};
        vecs[6] = '{1'b1, 32'h3C,       1'b0, 32'h0,    1'b1, 1'b0, 1'b0, 32'hA000_000F};
        vecs[7] = '{1'b1, 32'h8000_0000,1'b0, 32'h0,    1'b1, 1'b0, 1'b1, 32'h0};
        vecs[8] = '{1'b0, 32'h8,        1'b0, 32'h10,   1'b0, 1'b0, 1'b0, 32'h0};

        rst_n = 1'b0; if_req = 0; ld_req = 0; wr_req = 0; boot_done = 0;
        if_addr = 0; ld_addr = 0; wr_addr = 0; wr_data = 0;

        // reset state
        tick(); tick(); #3;
        chk("rst_running", running, 0);
        chk("rst_if_rvalid", if_rvalid, 0);
        chk("rst_ld_rvalid", ld_rvalid, 0);
        chk("rst_rom_we", rom_we, 0);
        chk("rst_d2_running", d2_running, 1);

        // boot load with IF knocking during BOOT
        rst_n = 1'b1;
        for (int k = 0; k < 17; k++) begin
            tick();
            if (k == 15) begin
                wr_addr = 32'h2; wr_data = 32'hDEAD_BEEF;
            end else begin
                int idx;
                idx = (k < 15) ? k : 15;
                wr_addr = 32'(idx) * 4; wr_data = exp_word(idx);
            end
            wr_req = 1; boot_done = (k == 16); if_req = 1; if_addr = 32'h8;
            #3;
            chk($sformatf("boot_wr_gnt%0d", k), wr_gnt, 1);
            chk($sformatf("boot_rom_we%0d", k), rom_we, (k == 15) ? 0 : 1);
            chk($sformatf("boot_rom_addr%0d", k), rom_addr, wr_addr);
            chk($sformatf("boot_if_gnt%0d", k), if_gnt, 0);
            chk($sformatf("boot_running%0d", k), running, 0);
            chk($sformatf("d2_wr_gnt%0d", k), d2_wr_gnt, 0);
            chk($sformatf("d2_rom_we%0d", k), d2_rom_we, 0);
        end
        tick();
        wr_req = 0; boot_done = 0; if_req = 0;
        #3;
        chk("run_after_boot", running, 1);
        chk("d2_running", d2_running, 1);

        // fetch latency, loader ignored in RUN
        tick();
        if_req = 1; if_addr = 32'h8; wr_req = 1; wr_addr = 32'h0;
        #3;
        chk("fetch_gnt", if_gnt, 1);
        chk("fetch_rom_addr", rom_addr, 32'h8);
        chk("run_wr_gnt", wr_gnt, 0);
        chk("run_rom_we", rom_we, 0);
        tick();
        if_req = 0; wr_req = 0;
        #3;
        chk("fetch_rvalid", if_rvalid, 1);
        chk("fetch_rdata", if_rdata, 32'h0000_0013);
        chk("fetch_ld_rvalid", ld_rvalid, 0);

        // table vectors: one request cycle, one response cycle
        foreach (vecs[i]) begin
            tick();
            if_req = vecs[i].if_req; if_addr = vecs[i].if_addr;
            ld_req = vecs[i].ld_req; ld_addr = vecs[i].ld_addr;
            #3;
            chk($sformatf("v%0d_if_gnt", i), if_gnt, vecs[i].e_if);
            chk($sformatf("v%0d_ld_gnt", i), ld_gnt, vecs[i].e_ld);
            chk($sformatf("v%0d_rom_addr", i), rom_addr, vecs[i].e_ld ? vecs[i].ld_addr : vecs[i].if_addr);
            tick();
            if_req = 0; ld_req = 0;
            #3;
            chk($sformatf("v%0d_if_rvalid", i), if_rvalid, vecs[i].e_if);
            chk($sformatf("v%0d_ld_rvalid", i), ld_rvalid, vecs[i].e_ld);
            if (vecs[i].e_if) begin
                chk($sformatf("v%0d_if_err", i), if_err, vecs[i].e_err);
                chk($sformatf("v%0d_if_rdata", i), if_rdata, vecs[i].e_data);
            end
            if (vecs[i].e_ld) begin
                chk($sformatf("v%0d_ld_err", i), ld_err, vecs[i].e_err);
                chk($sformatf("v%0d_ld_rdata", i), ld_rdata, vecs[i].e_data);
            end
        end

        // contention: LD x4, IF, LD x4
        for (int c = 0; c < 9; c++) begin
            tick();
            if_req = 1; if_addr = 32'h8; ld_req = 1; ld_addr = 32'(c + 4) * 4;
            #3;
            chk($sformatf("cont%0d_if_gnt", c), if_gnt, (c == 4) ? 1 : 0);
            chk($sformatf("cont%0d_ld_gnt", c), ld_gnt, (c == 4) ? 0 : 1);
            if (c > 0) begin
                chk($sformatf("cont%0d_if_rvalid", c), if_rvalid, (c == 5) ? 1 : 0);
                chk($sformatf("cont%0d_ld_rvalid", c), ld_rvalid, (c == 5) ? 0 : 1);
                if (c == 5) chk("cont_if_rdata", if_rdata, 32'h0000_0013);
                else        chk($sformatf("cont%0d_ld_rdata", c), ld_rdata, exp_word(c + 3));
            end
        end
        tick();
        if_req = 0; ld_req = 0;
        #3;
        chk("cont_last_ld_rvalid", ld_rvalid, 1);
        chk("cont_last_ld_rdata", ld_rdata, exp_word(12));

        // randomized traffic against a reference model
        pv_if = 0; pv_ld = 0; p_err = 0; p_data = 0; starve = 0;
        for (int n = 0; n < 400; n++) begin
            tick();
            ir = 1'($urandom_range(0, 1)); lr = 1'($urandom_range(0, 1));
            if_req = ir; ld_req = lr; if_addr = rnd_addr(); ld_addr = rnd_addr();
            #3;
            chk("rnd_if_rvalid", if_rvalid, pv_if);
            chk("rnd_ld_rvalid", ld_rvalid, pv_ld);
            if (pv_if) begin
                chk("rnd_if_err", if_err, p_err);
                chk("rnd_if_rdata", if_rdata, p_data);
            end
            if (pv_ld) begin
                chk("rnd_ld_err", ld_err, p_err);
                chk("rnd_ld_rdata", ld_rdata, p_data);
            end
            exp_if = (ir && lr) ? (starve >= 4) : ir;
            exp_ld = lr && !exp_if;
            chk("rnd_if_gnt", if_gnt, exp_if);
            chk("rnd_ld_gnt", ld_gnt, exp_ld);
            a = exp_ld ? ld_addr : if_addr;
            bad = is_bad(a);
            pv_if = exp_if; pv_ld = exp_ld; p_err = bad && (exp_if || exp_ld);
            p_data = bad ? 32'd0 : exp_word(int'(a / 4));
            starve = (ir && !exp_if) ? ((starve < 4) ? starve + 1 : 4) : 0;
        end
        tick();
        if_req = 0; ld_req = 0;
        #3;
        chk("rnd_tail_if_rvalid", if_rvalid, pv_if);
        chk("rnd_tail_ld_rvalid", ld_rvalid, pv_ld);

        // reset while a fetch response is in flight
        tick();
        if_req = 1; if_addr = 32'h8;
        #3;
        chk("mid_if_gnt", if_gnt, 1);
        tick();
        rst_n = 0;
        #3;
        tick();
        #3;
        chk("mid_if_rvalid", if_rvalid, 0);
        chk("mid_running", running, 0);
        chk("mid_if_gnt_boot", if_gnt, 0);
        rst_n = 1;
        tick();
        #3;
        chk("mid_still_boot", running, 0);
        chk("mid_if_rvalid2", if_rvalid, 0);
        chk("mid_d2_running", d2_running, 1);
        if_req = 0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
